ps2_kb_evt_rx: RTL and testbench

- Second-generation PS/2 keyboard receiver. Replaces edge-count-only reception with filtered line sampling, odd-parity and stop-bit checking, frame timeout recovery, and E0/F0 prefix folding.
- Completed key events go into a parametrised FIFO drained with a valid/ready handshake, so bursts are not lost while software is busy.
- Sits between the raw PS/2 pins and the scan-code translation and MMIO status logic.

---
 rtl/ps2_pkg.sv | 21 ++
 rtl/ps2_kb_evt_rx_fifo.sv | 57 +++++
 rtl/ps2_kb_evt_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_kb_evt_rx.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 keyboard event receiver:
// frame state, prefix byte codes and the event record.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_STOP = 2'd3
  } frame_st_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_kb_evt_rx_fifo.sv
// Synchronous event FIFO (power-of-2 depth).
// Ports: push/din in, pop/dout out, full/empty/count status.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ps2_evt_t               din,
  input  logic                   pop,
  output ps2_evt_t               dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  ps2_evt_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     cnt;
  logic            do_push;
  logic            do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // a full FIFO still takes a push when the head leaves this cycle
  assign do_push = push & (~full | do_pop);
  assign count   = cnt;
  // head reads as zero when empty so reset leaves outputs at 0
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kb_evt_rx.sv
// PS/2 keyboard receiver: filtered sampling, framing checks,
// E0/F0 folding, event FIFO with valid/ready drain.
module ps2_kb_evt_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        PS2_CLK_i,
  input  logic                        PS2_DAT_i,
  output logic                        evt_valid_o,
  input  logic                        evt_ready_i,
  output logic [7:0]                  evt_code_o,
  output logic                        evt_brk_o,
  output logic                        evt_ext_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
  output logic                        ovf_o,
  input  logic                        ovf_clr_i,
  output logic                        par_err_o,
  output logic                        frm_err_o,
  output logic [7:0]                  err_cnt_o
);

  localparam int FW = $clog2(FILT_LEN);
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [1:0]    ck_sync;
  logic [1:0]    dt_sync;
  logic          ck_f;
  logic          dt_f;
  logic [FW-1:0] ck_fc;
  logic [FW-1:0] dt_fc;
  logic          ck_f_d;
  logic          fall;

  always_ff @(posedge clk) begin
    if (rst) begin
      ck_sync <= 2'b11;
      dt_sync <= 2'b11;
    end else begin
      ck_sync <= {ck_sync[0], PS2_CLK_i};
      dt_sync <= {dt_sync[0], PS2_DAT_i};
    end
  end

  // filtered value flips on the FILT_LEN-th differing sample in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      ck_f  <= 1'b1;
      ck_fc <= '0;
    end else if (ck_sync[1] == ck_f) begin
      ck_fc <= '0;
    end else if (ck_fc == FW'(FILT_LEN-1)) begin
      ck_f  <= ck_sync[1];
      ck_fc <= '0;
    end else begin
      ck_fc <= ck_fc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dt_f  <= 1'b1;
      dt_fc <= '0;
    end else if (dt_sync[1] == dt_f) begin
      dt_fc <= '0;
    end else if (dt_fc == FW'(FILT_LEN-1)) begin
      dt_f  <= dt_sync[1];
      dt_fc <= '0;
    end else begin
      dt_fc <= dt_fc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ck_f_d <= 1'b1;
      fall   <= 1'b0;
    end else begin
      ck_f_d <= ck_f;
      fall   <= ck_f_d & ~ck_f;
    end
  end

  frame_st_t     st;
  logic [7:0]    sr;
  logic [2:0]    bcnt;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          byte_vld;
  logic          par_err;
  logic          frm_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      sr       <= '0;
      bcnt     <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      byte_vld <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      byte_vld <= 1'b0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      if (st == ST_IDLE || fall) to_cnt <= '0;
      else                       to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        unique case (st)
          ST_IDLE: begin
            if (!dt_f) begin
              sr   <= '0;
              bcnt <= '0;
              st   <= ST_DATA;
            end else begin
              frm_err <= 1'b1;
            end
          end
          ST_DATA: begin
            sr   <= {dt_f, sr[7:1]};
            bcnt <= bcnt + 3'd1;
            if (bcnt == 3'd7) st <= ST_PAR;
          end
          ST_PAR: begin
            par_bit <= dt_f;
            st      <= ST_STOP;
          end
          ST_STOP: begin
            if (dt_f && ^{sr, par_bit}) byte_vld <= 1'b1;
            else                        par_err  <= 1'b1;
            st <= ST_IDLE;
          end
          default: st <= ST_IDLE;
        endcase
      end else if (st != ST_IDLE &&
                   to_cnt == TW'(TIMEOUT_CYC-1)) begin
        st      <= ST_IDLE;
        frm_err <= 1'b1;
        to_cnt  <= '0;
      end
    end
  end

  logic     ext_f;
  logic     brk_f;
  logic     push;
  ps2_evt_t push_evt;

  // sr holds the byte until the next start bit, far past byte_vld
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_f    <= 1'b0;
      brk_f    <= 1'b0;
      push     <= 1'b0;
      push_evt <= '0;
    end else begin
      push <= 1'b0;
      if (par_err || frm_err) begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end else if (byte_vld) begin
        unique case (1'b1)
          (sr == PS2_EXT): ext_f <= 1'b1;
          (sr == PS2_BRK): brk_f <= 1'b1;
          default: begin
            push          <= 1'b1;
            push_evt.ext  <= ext_f;
            push_evt.brk  <= brk_f;
            push_evt.code <= sr;
            ext_f         <= 1'b0;
            brk_f         <= 1'b0;
          end
        endcase
      end
    end
  end

  ps2_evt_t head;
  logic     full;
  logic     empty;
  logic     pop;

  assign pop = ~empty & evt_ready_i;

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_evt),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_o     <= 1'b0;
      err_cnt_o <= '0;
    end else begin
      if (push && full && !pop) ovf_o <= 1'b1;
      else if (ovf_clr_i)       ovf_o <= 1'b0;
      if ((par_err || frm_err) && err_cnt_o != 8'hFF)
        err_cnt_o <= err_cnt_o + 8'd1;
    end
  end

  assign evt_valid_o = ~empty;
  assign evt_code_o  = head.code;
  assign evt_brk_o   = head.brk;
  assign evt_ext_o   = head.ext;
  assign par_err_o   = par_err;
  assign frm_err_o   = frm_err;

endmodule

// File: tb/tb_ps2_kb_evt_rx.sv
// Randomized bench for ps2_kb_evt_rx against a frame-level
// reference model (expected event queue, error counts).
module tb_ps2_kb_evt_rx;
  import ps2_pkg::*;

  localparam int FL = 4;
  localparam int TO = 300;
  localparam int FD = 8;

  logic       clk = 0;
  logic       rst = 1;
  logic       ps2_clk = 1;
  logic       ps2_dat = 1;
  logic       evt_valid;
  logic       evt_ready = 0;
  logic [7:0] evt_code;
  logic       evt_brk;
  logic       evt_ext;
  logic [3:0] fifo_cnt;
  logic       ovf;
  logic       ovf_clr = 0;
  logic       par_err;
  logic       frm_err;
  logic [7:0] err_cnt;

  ps2_kb_evt_rx #(
    .FILT_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst),
    .PS2_CLK_i(ps2_clk), .PS2_DAT_i(ps2_dat),
    .evt_valid_o(evt_valid), .evt_ready_i(evt_ready),
    .evt_code_o(evt_code), .evt_brk_o(evt_brk),
    .evt_ext_o(evt_ext), .fifo_cnt_o(fifo_cnt),
    .ovf_o(ovf), .ovf_clr_i(ovf_clr),
    .par_err_o(par_err), .frm_err_o(frm_err),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  ps2_evt_t exp_q[$];
  ps2_evt_t obs_q[$];
  bit       m_ext, m_brk, m_ovf;
  int       m_err, m_perr, m_ferr;

  // observation side
  int o_perr = 0;
  int o_ferr = 0;
  int bv_cyc = 0;
  int lat = -1;
  bit prev_v = 0;
  int rdy_mode = 0;

  always @(negedge clk) begin
    if (par_err) o_perr++;
    if (frm_err) o_ferr++;
    if (evt_valid && evt_ready)
      obs_q.push_back(ps2_evt_t'({evt_ext, evt_brk, evt_code}));
    if (dut.byte_vld) bv_cyc = cyc;
    if (evt_valid && !prev_v) lat = cyc - bv_cyc;
    prev_v = evt_valid;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       evt_ready = 1'b0;
        1:       evt_ready = 1'b1;
        default: evt_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic match();
    while (obs_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        chk("unexp_evt", obs_q.pop_front(), 32'h3ff);
      end else begin
        chk("evt", obs_q.pop_front(), exp_q.pop_front());
      end
    end
  endtask

  function automatic int sat(int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  task automatic model_err(bit is_par);
    m_err = sat(m_err);
    if (is_par) m_perr++;
    else        m_ferr++;
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic model_byte(logic [7:0] b, bit bad);
    int occ;
    if (bad) begin
      model_err(1);
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      occ = exp_q.size() - obs_q.size();
      if (occ < FD) exp_q.push_back(ps2_evt_t'({m_ext, m_brk, b}));
      else          m_ovf = 1;
      m_ext = 0;
      m_brk = 0;
    end
    match();
  endtask

  task automatic ps2_bit(bit v, bit g);
    ps2_dat = v;
    if (g) begin
      tick(2);
      ps2_clk = 0;
      tick(FL - 1);
      ps2_clk = 1;
      tick(4);
    end else begin
      tick(6);
    end
    ps2_clk = 0;
    tick(10);
    ps2_clk = 1;
    tick(4);
  endtask

  task automatic send_frame(logic [7:0] b, bit bp, bit bs, bit g);
    ps2_bit(0, g);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], g);
    ps2_bit((~^b) ^ bp, g);
    ps2_bit(!bs, g);
    ps2_dat = 1;
    tick(20);
    model_byte(b, bp | bs);
  endtask

  task automatic partial(int n);
    ps2_bit(0, 0);
    for (int i = 0; i < n; i++) ps2_bit(1'($urandom_range(0, 1)), 0);
    ps2_dat = 1;
  endtask

  task automatic bad_start();
    ps2_dat = 1;
    tick(2);
    ps2_clk = 0;
    tick(8);
    ps2_clk = 1;
    tick(8);
    model_err(0);
  endtask

  task automatic sync_chk(string t);
    match();
    chk({t, "_cnt"}, fifo_cnt, exp_q.size());
    chk({t, "_ovf"}, ovf, m_ovf);
    chk({t, "_errcnt"}, err_cnt, m_err);
    chk({t, "_perr"}, o_perr, m_perr);
    chk({t, "_ferr"}, o_ferr, m_ferr);
  endtask

  task automatic drain(string t);
    int i;
    rdy_mode = 1;
    i = 0;
    tick(2);
    while (evt_valid && i < 400) begin
      tick(1);
      i++;
    end
    if (i >= 400) chk({t, "_drain_to"}, 1, 0);
    rdy_mode = 0;
    tick(3);
    match();
    chk({t, "_left"}, exp_q.size(), 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    obs_q.delete();
    m_ext = 0; m_brk = 0; m_ovf = 0; m_err = 0;
    m_perr = o_perr;
    m_ferr = o_ferr;
  endtask

  task automatic chk_zero(string t);
    chk({t, "_valid"}, evt_valid, 0);
    chk({t, "_cnt"}, fifo_cnt, 0);
    chk({t, "_ovf"}, ovf, 0);
    chk({t, "_err"}, err_cnt, 0);
    chk({t, "_head"}, {evt_ext, evt_brk, evt_code}, 0);
    chk({t, "_pulse"}, {par_err, frm_err}, 0);
  endtask

  logic [7:0] b;
  int         r;

  initial begin
    model_reset();
    tick(3);
    rst = 0;
    tick(2);
    chk_zero("reset");

    // single make code, latency and head fields
    send_frame(8'h1C, 0, 0, 0);
    chk("lat", lat, 2);
    chk("t1_head", {evt_ext, evt_brk, evt_code}, 10'h01C);
    sync_chk("t1");
    drain("t1");

    // extended release folds into one event
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    sync_chk("t2_pre");
    send_frame(8'h75, 0, 0, 0);
    chk("t2_head", {evt_ext, evt_brk, evt_code}, 10'h375);
    sync_chk("t2");
    drain("t2");

    // parity error clears pending prefix
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h1C, 1, 0, 0);
    sync_chk("t3_err");
    send_frame(8'h1C, 0, 0, 0);
    sync_chk("t3");
    drain("t3");

    // aborted frame times out, next frame still good
    partial(4);
    tick(TO + 50);
    model_err(0);
    sync_chk("t4_to");
    send_frame(8'h2A, 0, 0, 0);
    sync_chk("t4");
    drain("t4");

    // fill past depth with the consumer stalled
    for (int i = 0; i < FD + 1; i++) begin
      do b = 8'($urandom_range(0, 255));
      while (b == 8'hE0 || b == 8'hF0);
      send_frame(b, 0, 0, 0);
    end
    sync_chk("t5_full");
    chk("t5_cnt8", fifo_cnt, FD);
    drain("t5");
    ovf_clr = 1;
    tick(1);
    ovf_clr = 0;
    m_ovf = 0;
    tick(1);
    sync_chk("t5_clr");

    // random traffic with a random consumer
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 7);
      case (r)
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = 8'hE1;
        default: b = 8'($urandom_range(0, 255));
      endcase
      send_frame(b, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 14) == 0), 0);
    end
    drain("t6");
    sync_chk("t6");

    // error counter saturates
    for (int i = 0; i < 260; i++) bad_start();
    sync_chk("t7");
    chk("t7_sat", err_cnt, 8'hFF);

    // short clock glitches never sample
    for (int i = 0; i < 5; i++) begin
      ps2_clk = 0;
      tick(FL - 1);
      ps2_clk = 1;
      tick(10);
    end
    sync_chk("t8_glitch");
    send_frame(8'h33, 0, 0, 1);
    sync_chk("t8_gframe");
    chk("t8_head", {evt_ext, evt_brk, evt_code}, 10'h033);

    // reset in the middle of a frame
    send_frame(8'hE0, 0, 0, 0);
    partial(3);
    rst = 1;
    tick(1);
    rst = 0;
    model_reset();
    tick(1);
    chk_zero("t8_rst");
    send_frame(8'h2A, 0, 0, 0);
    sync_chk("t8");
    chk("t8_head2", {evt_ext, evt_brk, evt_code}, 10'h02A);
    drain("t8");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
